// File: rtl/message_reg_uart_tx.sv
// Message register and 8N1 UART transmitter for the Hangman radio link.
// A rising edge on ready latches msg and launches one frame on tx_serial.
module message_reg_uart_tx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       ready,
  input  logic [7:0] msg,
  output logic [7:0] tx_byte,
  output logic       tx_ctrl,
  output logic       tx_serial,
  output logic       blue,
  output logic       transmit_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          ready_q;
  logic [7:0]    tx_byte_q;
  logic          tx_ctrl_q;
  logic          capture;

  // A pending start pulse counts as busy, so edges are never queued.
  assign capture = ready && !ready_q && (state_q == IDLE) && !tx_ctrl_q;

  always_ff @(posedge clk) begin
    if (nRst) begin
      ready_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_ctrl_q <= 1'b0;
    end else begin
      ready_q   <= ready;
      tx_ctrl_q <= capture;
      if (capture) begin
        tx_byte_q <= msg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (tx_ctrl_q) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          state_d   = DONE;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_byte cannot change while a frame is in flight, so it doubles as the shift data.
  always_comb begin
    tx_serial      = 1'b1;
    blue           = 1'b0;
    transmit_ready = 1'b0;
    case (state_q)
      START: begin
        tx_serial = 1'b0;
        blue      = 1'b1;
      end
      DATA: begin
        tx_serial = tx_byte_q[bit_idx_q];
        blue      = 1'b1;
      end
      STOP:    blue = 1'b1;
      DONE:    transmit_ready = 1'b1;
      default: tx_serial = 1'b1;
    endcase
  end

  assign tx_byte = tx_byte_q;
  assign tx_ctrl = tx_ctrl_q;

endmodule

// File: tb/tb_message_reg_uart_tx.sv
// Bench for message_reg_uart_tx: expected frames are queued when a capture is
// driven and compared by a line monitor when the frame appears on tx_serial.
module tb_message_reg_uart_tx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       nRst;
  logic       ready;
  logic [7:0] msg;
  logic [7:0] tx_byte;
  logic       tx_ctrl;
  logic       tx_serial;
  logic       blue;
  logic       transmit_ready;

  always #5 clk = ~clk;

  message_reg_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .ready         (ready),
    .msg           (msg),
    .tx_byte       (tx_byte),
    .tx_ctrl       (tx_ctrl),
    .tx_serial     (tx_serial),
    .blue          (blue),
    .transmit_ready(transmit_ready)
  );

  // line holds the ten line levels, start bit in bit 9, stop bit in bit 0
  typedef struct {
    logic [7:0] msg;
    logic [9:0] line;
  } frame_t;

  frame_t sb_q[$];
  frame_t vec[6];

  int checks = 0;
  int failures = 0;
  int frames_done = 0;
  int aborts = 0;
  int ctrl_cnt = 0;
  int tr_cnt = 0;
  int c0, f0, a0, t0, low;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (tx_ctrl === 1'b1) ctrl_cnt++;
    if (transmit_ready === 1'b1) tr_cnt++;
  end

  // Line monitor: one frame per blue rise, sampled mid-bit.
  initial begin : monitor
    logic [9:0] line;
    logic [7:0] byte_seen;
    int hi, early_tr;
    bit aborted;
    frame_t exp_f;
    forever begin
      @(negedge clk);
      if (nRst === 1'b0 && blue === 1'b1) begin
        line = '0;
        hi = 0;
        early_tr = 0;
        aborted = 0;
        byte_seen = tx_byte;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (nRst !== 1'b0) begin
            aborted = 1;
            break;
          end
          if (k % CPB == CPB / 2) line = {line[8:0], tx_serial};
          if (blue === 1'b1) hi++;
          if (transmit_ready === 1'b1) early_tr++;
          @(negedge clk);
        end
        if (aborted) begin
          if (sb_q.size() > 0) sb_q.delete(0);
          aborts++;
        end else begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual_line=%b required=no_frame", line);
          end else begin
            exp_f = sb_q.pop_front();
            $display("frame msg=0x%02h line=%b", exp_f.msg, line);
            chk("frame_line", 32'(line), 32'(exp_f.line));
            chk("frame_byte", 32'(byte_seen), 32'(exp_f.msg));
          end
          chk("blue_cycles", hi, 10 * CPB);
          chk("early_transmit_ready", early_tr, 0);
          chk("transmit_ready_at_end", 32'(transmit_ready), 1);
          chk("blue_low_at_done", 32'(blue), 0);
          frames_done++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames_done < target && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(frames_done >= target), 1);
  endtask

  // Called at a negedge with ready low for at least one prior edge.
  task automatic start_frame(input logic [7:0] m, input logic [9:0] line);
    frame_t f;
    f.msg  = m;
    f.line = line;
    sb_q.push_back(f);
    msg   = m;
    ready = 1'b1;
    @(negedge clk);
    chk("tx_ctrl_pulse", 32'(tx_ctrl), 1);
    chk("tx_byte_capture", 32'(tx_byte), 32'(m));
    @(negedge clk);
    chk("tx_ctrl_single", 32'(tx_ctrl), 0);
  endtask

  initial begin
    vec[0] = '{8'h6D, 10'b0101101101};
    vec[1] = '{8'h00, 10'b0000000001};
    vec[2] = '{8'hFF, 10'b0111111111};
    vec[3] = '{8'h01, 10'b0100000001};
    vec[4] = '{8'h80, 10'b0000000011};
    vec[5] = '{8'h55, 10'b0101010101};

    nRst  = 1'b1;
    ready = 1'b0;
    msg   = 8'h00;
    cycles(2);
    chk("rst_tx_serial", 32'(tx_serial), 1);
    chk("rst_blue", 32'(blue), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_tx_ctrl", 32'(tx_ctrl), 0);
    chk("rst_transmit_ready", 32'(transmit_ready), 0);

    nRst = 1'b0;
    msg  = 8'hAB;
    c0   = ctrl_cnt;
    low  = 0;
    repeat (6500) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) low++;
    end
    chk("idle_no_ctrl", ctrl_cnt - c0, 0);
    chk("idle_line_high", low, 0);

    // Level ready held high: exactly one frame, later msg changes ignored.
    c0 = ctrl_cnt;
    f0 = frames_done;
    start_frame(8'hAB, 10'b0110101011);
    msg = 8'h00;
    cycles(7500);
    chk("hold_frames", frames_done - f0, 1);
    chk("hold_ctrl_pulses", ctrl_cnt - c0, 1);
    ready = 1'b0;
    cycles(75);

    for (int i = 0; i < 6; i++) begin
      c0 = ctrl_cnt;
      f0 = frames_done;
      start_frame(vec[i].msg, vec[i].line);
      cycles(20);
      ready = 1'b0;
      msg   = ~vec[i].msg;
      wait_frames(f0 + 1, "vec_frame_done");
      chk("vec_ctrl_pulses", ctrl_cnt - c0, 1);
      cycles(75);
    end

    // Rising edge while busy is dropped, not queued.
    c0 = ctrl_cnt;
    f0 = frames_done;
    start_frame(8'hC3, 10'b0110000111);
    cycles(CPB);
    ready = 1'b0;
    cycles(5);
    msg   = 8'h12;
    ready = 1'b1;
    cycles(200);
    chk("busy_tx_byte_kept", 32'(tx_byte), 32'hC3);
    ready = 1'b0;
    wait_frames(f0 + 1, "busy_frame_done");
    cycles(20);
    chk("busy_frames", frames_done - f0, 1);
    chk("busy_ctrl_pulses", ctrl_cnt - c0, 1);

    // Reset in the middle of DATA aborts the frame silently.
    f0 = frames_done;
    a0 = aborts;
    t0 = tr_cnt;
    start_frame(8'h5A, 10'b0010110101);
    ready = 1'b0;
    cycles(3 * CPB);
    nRst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_serial", 32'(tx_serial), 1);
    chk("midrst_blue", 32'(blue), 0);
    chk("midrst_transmit_ready", 32'(transmit_ready), 0);
    chk("midrst_tx_ctrl", 32'(tx_ctrl), 0);
    chk("midrst_tx_byte", 32'(tx_byte), 0);
    @(negedge clk);
    nRst = 1'b0;
    cycles(12 * CPB);
    chk("midrst_no_transmit_ready", tr_cnt - t0, 0);
    chk("midrst_aborted", aborts - a0, 1);
    chk("midrst_no_frame", frames_done - f0, 0);

    f0 = frames_done;
    start_frame(8'h3C, 10'b0001111001);
    cycles(20);
    ready = 1'b0;
    wait_frames(f0 + 1, "post_rst_frame_done");
    cycles(10);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/message_reg_uart_tx.md
# message_reg_uart_tx

Message register plus UART transmitter for the wireless Hangman link. Captures an 8-bit message from the game logic on each rising edge of `ready`, then serialises it as one 8N1 UART frame (start, 8 data bits LSB first, stop) on `tx_serial`. Drives a transmit-active indicator (`blue`) and a one-cycle completion strobe (`transmit_ready`). Sits between the game/message logic and the radio-module serial input.

## Interface
- `CLKS_PER_BIT`, default 100: clock cycles per UART bit. Must be ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `nRst`  input  1  reset; one clock, reset is synchronous and active-high (1 = reset).
- `ready`  input  1  message-ready level from upstream; each 0→1 transition requests one transmission.
- `msg`  input  8  message byte; sampled on the capture cycle.
- `tx_byte`  output  8  registered copy of the last captured message; feeds the transmitter.
- `tx_ctrl`  output  1  one-cycle start pulse from message register to transmitter.
- `tx_serial`  output  1  UART serial line; idles high.
- `blue`  output  1  high while a frame is on the line (START through STOP).
- `transmit_ready`  output  1  one-cycle pulse after a frame's stop bit completes.

## Operation
- Message register: `ready_q` samples `ready` every clock. Capture condition: `ready`=1 and `ready_q`=0 while transmitter is IDLE and `tx_ctrl`=0. On capture, `tx_byte` ← `msg` and `tx_ctrl` ← 1 for exactly one cycle.
- Level `ready` held high does not retransmit; a new frame requires `ready` to fall and rise again.
- A rising edge of `ready` while the transmitter is busy (state ≠ IDLE, or `tx_ctrl`=1) is ignored and not queued.
- `ready_q` resets to 0, so `ready`=1 on the first cycle after reset counts as a rising edge.
- Transmitter FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: `tx_serial`=1; on `tx_ctrl`=1 load shift data from `tx_byte`, clear counters, go to START.
  - START: `tx_serial`=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: `tx_serial` = `tx_byte[bit_idx]`, bit_idx 0..7, each bit held CLKS_PER_BIT cycles; after bit 7 → STOP.
  - STOP: `tx_serial`=1 for CLKS_PER_BIT cycles → DONE.
  - DONE: `transmit_ready`=1 for one cycle, `tx_serial`=1 → IDLE.
- `blue`=1 in START, DATA, STOP; 0 in IDLE and DONE.
- Bit counter 3 bits; clock counter wide enough for CLKS_PER_BIT−1, counts 0..CLKS_PER_BIT−1 then clears.
- Transmitter uses the byte latched in `tx_byte`; changes on `msg` after capture do not affect the frame in flight.

## Timing
- Reset values: `tx_serial`=1, `tx_byte`=0x00, `tx_ctrl`=0, `blue`=0, `transmit_ready`=0, FSM=IDLE, counters 0, `ready_q`=0.
- Reset asserted mid-frame aborts at that edge; `tx_serial`=1 from that edge on; no `transmit_ready` pulse.
- Edge E: capture (`ready`=1, `ready_q`=0). After E: `tx_byte` valid, `tx_ctrl`=1.
- Edge E+1: FSM enters START; `tx_serial`=0, `blue`=1.
- Start bit spans E+1..E+1+CLKS_PER_BIT; data bit n starts at E+1+(n+1)·CLKS_PER_BIT; stop bit starts at E+1+9·CLKS_PER_BIT.
- `transmit_ready` high for cycle starting at E+1+10·CLKS_PER_BIT; `blue` falls at the same edge.
- Earliest next capture: edge after DONE (FSM back in IDLE).

## Test plan
- Reset: hold `nRst`=1 for 2 cycles with `ready`=0 → `tx_serial`=1, `blue`=0, `tx_byte`=0x00, `tx_ctrl`=0, `transmit_ready`=0.
- Idle with `msg`=0xAB, `ready`=0 for 6500 cycles → no `tx_ctrl` pulse, `tx_serial` stays 1.
- `ready` 0→1 with `msg`=0xAB, CLKS_PER_BIT=100 → `tx_byte`=0xAB, one `tx_ctrl` pulse, line 0,1,1,0,1,0,1,0,1,1 each 100 cycles, `blue` high 1000 cycles, one `transmit_ready` pulse.
- Hold `ready`=1 for 7500 cycles → exactly one frame; no further `tx_ctrl` pulses.
- `ready` low 75 cycles, then high with `msg`=0x6D → second frame 0,1,0,1,1,0,1,1,0,1; `tx_byte`=0x6D.
- Assert `nRst` during DATA of a frame → `tx_serial`=1, `blue`=0 next cycle; no `transmit_ready`; next `ready` edge transmits normally.
